// File: rtl/uart_tx_mmio.sv
// ----------------------------------------------------------------------------
// uart_tx_mmio
//    Memory-mapped 8N1 UART transmitter for the processor data bus. Stores to
//    the IO page (mem_addr[22]=1) push bytes into a small FIFO. A serialiser
//    drains the FIFO onto the tx pin. Loads return a status word one cycle
//    later, which matches the RAM read latency.
//
//    Register map (offset = mem_addr[3:2]):
//       0 DATA   : write (wmask[0]) pushes wdata[7:0]; reads return 0
//       1 STATUS : read  -> {count[12:8], overrun[3], empty[2], full[1], busy[0]}
//                  write (wmask[0]) with wdata[3]=1 clears overrun
//       2,3      : writes ignored, reads return 0
//
// Ports:
//    clk        in   system clock
//    resetn     in   asynchronous active-low reset
//    mem_addr   in   [31:0] processor byte address
//    mem_wdata  in   [31:0] processor store data
//    mem_wmask  in   [3:0]  byte write mask, nonzero = store
//    mem_rstrb  in   processor read strobe
//    io_sel     out  combinational IO page select (mem_addr[22])
//    io_rdata   out  [31:0] registered read data, held when not read
//    tx         out  registered serial output, idle high
// ----------------------------------------------------------------------------
module uart_tx_mmio #(
   parameter int CLK_FREQ   = 27000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wmask,
   input  logic        mem_rstrb,
   output logic        io_sel,
   output logic [31:0] io_rdata,
   output logic        tx
);

   localparam int DIV = CLK_FREQ / BAUD;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int NW  = PW + 1;

   localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
   localparam logic [NW-1:0] DEPTH_N   = NW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic [7:0]      fifo_q [FIFO_DEPTH];
   logic [7:0]      fifo_d [FIFO_DEPTH];
   logic [PW-1:0]   wptr_q, wptr_d;
   logic [PW-1:0]   rptr_q, rptr_d;
   logic [NW-1:0]   count_q, count_d;
   logic            overrun_q, overrun_d;
   logic [31:0]     rdata_q, rdata_d;

   logic [1:0]      offset_s;
   logic            wr_data_s;
   logic            wr_clr_s;
   logic            rd_s;
   logic            full_s;
   logic            empty_s;
   logic            push_s;
   logic            pop_s;
   logic [31:0]     status_s;
   logic            unused_s;

   // Bus decode and FIFO flags; fullness is taken before any same-edge pop.
   always_comb begin
      offset_s  = mem_addr[3:2];
      wr_data_s = mem_addr[22] & mem_wmask[0] & (offset_s == 2'd0);
      wr_clr_s  = mem_addr[22] & mem_wmask[0] & (offset_s == 2'd1) & mem_wdata[3];
      rd_s      = mem_addr[22] & mem_rstrb;
      full_s    = (count_q == DEPTH_N);
      empty_s   = (count_q == {NW{1'b0}});
      push_s    = wr_data_s & ~full_s;
      pop_s     = (state_q == ST_IDLE) & ~empty_s;
      status_s        = 32'd0;
      status_s[0]     = (state_q != ST_IDLE);
      status_s[1]     = full_s;
      status_s[2]     = empty_s;
      status_s[3]     = overrun_q;
      status_s[12:8]  = 5'(count_q);
   end

   // FIFO storage, pointers, occupancy and sticky overrun flag.
   always_comb begin
      fifo_d  = fifo_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_s) begin
         fifo_d[wptr_q] = mem_wdata[7:0];
         wptr_d         = wptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
         wptr_d = wptr_q;
      end
      if (pop_s) begin
         rptr_d = rptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
         rptr_d = rptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + {{(NW-1){1'b0}}, 1'b1};
         2'b01:   count_d = count_q - {{(NW-1){1'b0}}, 1'b1};
         default: count_d = count_q;
      endcase
      if (wr_data_s & full_s) begin
         overrun_d = 1'b1;
      end else if (wr_clr_s) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
   end

   // Serialiser FSM next state; tx is derived from the next state so the pin
   // itself comes straight from a flop.
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      case (state_q)
         ST_IDLE: begin
            baud_d = {CW{1'b0}};
            if (!empty_s) begin
               shift_d = fifo_q[rptr_q];
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (baud_q == BAUD_LAST) begin
               baud_d    = {CW{1'b0}};
               bit_idx_d = 3'd0;
               state_d   = ST_DATA;
            end else begin
               baud_d = baud_q + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         ST_DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d    = {CW{1'b0}};
               shift_d   = {1'b0, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               baud_d = baud_q + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         ST_STOP: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = {CW{1'b0}};
               state_d = ST_IDLE;
            end else begin
               baud_d = baud_q + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            baud_d  = {CW{1'b0}};
            state_d = ST_IDLE;
         end
      endcase
      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shift_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   // Read data: capture the pre-edge status on an IO load, otherwise hold.
   always_comb begin
      if (rd_s) begin
         if (offset_s == 2'd1) begin
            rdata_d = status_s;
         end else begin
            rdata_d = 32'd0;
         end
      end else begin
         rdata_d = rdata_q;
      end
   end

   // State registers; reset aborts any frame and discards queued bytes.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         baud_q    <= {CW{1'b0}};
         bit_idx_q <= 3'd0;
         shift_q   <= 8'd0;
         tx_q      <= 1'b1;
         fifo_q    <= '{default: 8'd0};
         wptr_q    <= {PW{1'b0}};
         rptr_q    <= {PW{1'b0}};
         count_q   <= {NW{1'b0}};
         overrun_q <= 1'b0;
         rdata_q   <= 32'd0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         fifo_q    <= fifo_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
         rdata_q   <= rdata_d;
      end
   end

   assign io_sel   = mem_addr[22];
   assign io_rdata = rdata_q;
   assign tx       = tx_q;

   // Address/data bits this block does not decode.
   assign unused_s = ^{mem_addr[31:23], mem_addr[21:4], mem_addr[1:0],
                       mem_wdata[31:8], mem_wmask[3:1]};

endmodule

// File: tb/tb_uart_tx_mmio.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_mmio
//    Scoreboard bench for uart_tx_mmio with DIV = 4. Stimulus pushes the
//    expected frames and status reads into queues; a line decoder and a read
//    monitor pop and compare whenever the DUT produces a frame or read data.
// ----------------------------------------------------------------------------
module tb_uart_tx_mmio;

   localparam int CLK_FREQ = 16;
   localparam int BAUD     = 4;
   localparam int DIV      = CLK_FREQ / BAUD;

   localparam logic [31:0] A_DATA = 32'h0040_0000;
   localparam logic [31:0] A_STAT = 32'h0040_0004;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] mem_addr  = 32'd0;
   logic [31:0] mem_wdata = 32'd0;
   logic [3:0]  mem_wmask = 4'd0;
   logic        mem_rstrb = 1'b0;
   logic        io_sel;
   logic [31:0] io_rdata;
   logic        tx;

   uart_tx_mmio #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wmask (mem_wmask),
      .mem_rstrb (mem_rstrb),
      .io_sel    (io_sel),
      .io_rdata  (io_rdata),
      .tx        (tx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      int         gap;   // required idle-high cycles before this frame, -1 = any
   } frame_t;

   frame_t      tx_q[$];
   logic [31:0] rd_q[$];
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Read monitor: an IO load at one edge is checked on the following negedge.
   logic rd_pend = 1'b0;
   always @(posedge clk) rd_pend <= mem_rstrb & mem_addr[22] & resetn;

   always @(negedge clk) begin
      if (rd_pend) begin
         if (rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL read_unexpected: got 0x%08h, expected no read", io_rdata);
         end else begin
            check("status_read", io_rdata, rd_q.pop_front());
         end
      end
   end

   // Line decoder: every sample of a frame must match the expected level.
   int         dec_cyc  = -1;
   int         idle_cnt = 1000;
   int         bad_samples = 0;
   int         bit_i = 0;
   logic       have_exp = 1'b0;
   frame_t     cur;
   logic [9:0] exp_bits = 10'd0;
   logic [9:0] act_bits = 10'd0;

   always @(negedge clk) begin
      if (!resetn) begin
         dec_cyc  = -1;
         idle_cnt = 1000;
      end else begin
         if (dec_cyc < 0) begin
            if (tx === 1'b0) begin
               dec_cyc     = 0;
               bad_samples = 0;
               act_bits    = 10'd0;
               if (tx_q.size() == 0) begin
                  have_exp = 1'b0;
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame: start bit at %0t, expected idle line", $time);
               end else begin
                  have_exp = 1'b1;
                  cur      = tx_q.pop_front();
                  exp_bits = {1'b1, cur.data, 1'b0};
                  if (cur.gap >= 0) check("frame_gap", 32'(idle_cnt), 32'(cur.gap));
               end
            end else begin
               idle_cnt++;
            end
         end
         if (dec_cyc >= 0) begin
            bit_i = dec_cyc / DIV;
            if ((dec_cyc % DIV) == (DIV / 2)) act_bits[bit_i] = tx;
            if (have_exp && (tx !== exp_bits[bit_i])) bad_samples++;
            if (dec_cyc == 10 * DIV - 1) begin
               if (have_exp) begin
                  check("frame_bits", 32'(act_bits), 32'(exp_bits));
                  check("frame_timing", 32'(bad_samples), 32'd0);
               end
               dec_cyc  = -1;
               idle_cnt = 0;
            end else begin
               dec_cyc++;
            end
         end
      end
   end

   // Bus tasks: called at a negedge, return at the next negedge.
   task automatic store(input logic [31:0] a, input logic [31:0] d);
      mem_addr  = a;
      mem_wdata = d;
      mem_wmask = 4'h1;
      @(negedge clk);
      mem_wmask = 4'h0;
      mem_addr  = 32'd0;
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] exp);
      if (a[22]) rd_q.push_back(exp);
      mem_addr  = a;
      mem_rstrb = 1'b1;
      @(negedge clk);
      mem_rstrb = 1'b0;
      mem_addr  = 32'd0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_frame(input logic [7:0] d, input int gap);
      frame_t f;
      f.data = d;
      f.gap  = gap;
      tx_q.push_back(f);
   endtask

   // Assert reset just after an edge and check the outputs react at once.
   task automatic mid_reset(input string tag);
      #1;
      resetn = 1'b0;
      tx_q.delete();
      #1;
      check({tag, "_tx"}, 32'(tx), 32'd1);
      check({tag, "_rdata"}, io_rdata, 32'd0);
      @(negedge clk);
      idle(2);
      resetn = 1'b1;
      idle(1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0;
      idle(3);
      resetn = 1'b1;
      idle(2);

      // Reset mid-frame clears tx and io_rdata immediately.
      push_frame(8'h3C, -1);
      store(A_DATA, 32'h3C);
      idle(5);
      load(A_STAT, 32'h0000_0005);
      idle(10);
      @(posedge clk);
      mid_reset("reset_mid_frame");
      load(A_STAT, 32'h0000_0004);
      idle(2);

      // Single byte with store-to-start latency.
      push_frame(8'h55, -1);
      store(A_DATA, 32'h55);
      check("latency_e0", 32'(tx), 32'd1);
      @(negedge clk);
      check("latency_e1", 32'(tx), 32'd0);
      idle(8);
      load(A_STAT, 32'h0000_0005);
      idle(45);
      load(A_STAT, 32'h0000_0004);

      // Back-to-back frames with one idle cycle between them.
      push_frame(8'hA5, -1);
      push_frame(8'h00, 1);
      push_frame(8'hFF, 1);
      store(A_DATA, 32'hA5);
      store(A_DATA, 32'h00);
      store(A_DATA, 32'hFF);
      load(A_STAT, 32'h0000_0201);
      idle(130);
      load(A_STAT, 32'h0000_0004);

      // Overflow: sixth byte dropped, overrun and full set.
      push_frame(8'h01, -1);
      for (int i = 2; i <= 5; i++) push_frame(8'(i), 1);
      for (int i = 1; i <= 6; i++) store(A_DATA, 32'(i));
      load(A_STAT, 32'h0000_040B);
      idle(210);
      load(A_STAT, 32'h0000_000C);

      // Overrun clear leaves the FIFO alone; io_sel=0 accesses do nothing.
      store(A_STAT, 32'h0000_0008);
      load(A_STAT, 32'h0000_0004);
      mem_addr  = 32'h0000_0000;
      mem_wdata = 32'h0000_0077;
      mem_wmask = 4'hF;
      mem_rstrb = 1'b1;
      #1;
      check("io_sel_low", 32'(io_sel), 32'd0);
      @(negedge clk);
      mem_wmask = 4'h0;
      mem_rstrb = 1'b0;
      check("rdata_hold", io_rdata, 32'h0000_0004);
      mem_addr = A_STAT;
      #1;
      check("io_sel_high", 32'(io_sel), 32'd1);
      @(negedge clk);
      load(A_STAT, 32'h0000_0004);
      idle(50);

      // Reset during DATA bit 3 with two bytes queued.
      push_frame(8'h11, -1);
      store(A_DATA, 32'h11);
      store(A_DATA, 32'h22);
      store(A_DATA, 32'h33);
      repeat (16) @(posedge clk);
      mid_reset("reset_data_bit3");
      load(A_STAT, 32'h0000_0004);
      idle(100);

      check("frames_pending", 32'(tx_q.size()), 32'd0);
      check("reads_pending", 32'(rd_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
